// File: rtl/vga_timing_pkg.sv
// Mode constant sets and helpers shared by the VGA raster timing generator.
package vga_timing_pkg;

    // 640x480 @ 60 Hz, 25.175 MHz pixel rate, both syncs active-low
    localparam int  VGA640_H_ACTIVE = 640;
    localparam int  VGA640_H_FP     = 16;
    localparam int  VGA640_H_SYNC   = 96;
    localparam int  VGA640_H_BP     = 48;
    localparam int  VGA640_V_ACTIVE = 480;
    localparam int  VGA640_V_FP     = 10;
    localparam int  VGA640_V_SYNC   = 2;
    localparam int  VGA640_V_BP     = 33;
    localparam bit  VGA640_H_POL    = 1'b0;
    localparam bit  VGA640_V_POL    = 1'b0;

    // 800x600 @ 60 Hz, 40 MHz pixel rate, both syncs active-high
    localparam int  SVGA800_H_ACTIVE = 800;
    localparam int  SVGA800_H_FP     = 40;
    localparam int  SVGA800_H_SYNC   = 128;
    localparam int  SVGA800_H_BP     = 88;
    localparam int  SVGA800_V_ACTIVE = 600;
    localparam int  SVGA800_V_FP     = 1;
    localparam int  SVGA800_V_SYNC   = 4;
    localparam int  SVGA800_V_BP     = 23;
    localparam bit  SVGA800_H_POL    = 1'b1;
    localparam bit  SVGA800_V_POL    = 1'b1;

    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with sync and active decode.
// Outputs are decoded from the next count so they move on the same edge as it.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter bit POL    = 1'b0,
    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP),
    localparam int CNT_W = $clog2(TOTAL)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_adv,
    input  logic             i_restart,
    output logic [CNT_W-1:0] o_count,
    output logic             o_wrap,
    output logic             o_sync,
    output logic             o_active
);

    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(ACTIVE + FP + SYNC);
    localparam logic [CNT_W-1:0] ACT_END    = CNT_W'(ACTIVE);

    if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_param
        $error("vga_axis_counter: every segment length must be at least 1");
    end

    logic [CNT_W-1:0] count_q, count_d;
    logic             sync_q, sync_d;
    logic             active_q, active_d;
    logic             at_last;

    always_comb begin
        at_last  = (count_q == LAST);
        o_wrap   = i_adv && !i_restart && at_last;
        count_d  = count_q;
        if (i_restart) begin
            count_d = LAST;
        end else if (i_adv) begin
            count_d = at_last ? '0 : count_q + CNT_W'(1);
        end
        // LAST lies in the back porch, so restart also yields the idle levels
        sync_d   = ((count_d >= SYNC_START) && (count_d < SYNC_END)) ? POL : ~POL;
        active_d = (count_d < ACT_END);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q  <= LAST;
            sync_q   <= ~POL;
            active_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            sync_q   <= sync_d;
            active_q <= active_d;
        end
    end

    assign o_count  = count_q;
    assign o_sync   = sync_q;
    assign o_active = active_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA-class raster timing generator: syncs, active/blank, beam coordinates and strobes.
// Define VGA_TIMING_FRAME_CNT_EN to add the o_frame_cnt completed-frame counter.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE    = VGA640_H_ACTIVE,
    parameter int H_FP        = VGA640_H_FP,
    parameter int H_SYNC      = VGA640_H_SYNC,
    parameter int H_BP        = VGA640_H_BP,
    parameter int V_ACTIVE    = VGA640_V_ACTIVE,
    parameter int V_FP        = VGA640_V_FP,
    parameter int V_SYNC      = VGA640_V_SYNC,
    parameter int V_BP        = VGA640_V_BP,
    parameter bit H_POL       = VGA640_H_POL,
    parameter bit V_POL       = VGA640_V_POL,
    parameter int FRAME_CNT_W = 16,
    localparam int H_TOTAL    = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL    = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int X_W        = $clog2(H_TOTAL),
    localparam int Y_W        = $clog2(V_TOTAL)
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_pix_en,
    input  logic           i_restart,
    output logic           o_hs,
    output logic           o_vs,
    output logic           o_active,
    output logic           o_blanking,
    output logic [X_W-1:0] o_x,
    output logic [Y_W-1:0] o_y,
    output logic           o_line_start,
    output logic           o_frame_start,
    output logic           o_animate
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [FRAME_CNT_W-1:0] o_frame_cnt
`endif
);

    if (FRAME_CNT_W < 1) begin : g_bad_param
        $error("vga_timing_gen: FRAME_CNT_W must be at least 1");
    end

    logic h_wrap, v_wrap, h_active, v_active;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL)
    ) u_h_axis (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_adv    (i_pix_en),
        .i_restart(i_restart),
        .o_count  (o_x),
        .o_wrap   (h_wrap),
        .o_sync   (o_hs),
        .o_active (h_active)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL)
    ) u_v_axis (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_adv    (h_wrap),
        .i_restart(i_restart),
        .o_count  (o_y),
        .o_wrap   (v_wrap),
        .o_sync   (o_vs),
        .o_active (v_active)
    );

    assign o_active   = h_active && v_active;
    assign o_blanking = ~o_active;

    logic line_start_q, line_start_d;
    logic frame_start_q, frame_start_d;
    logic animate_q, animate_d;

    // h_wrap already excludes restart, so every strobe is suppressed by it
    always_comb begin
        line_start_d  = h_wrap;
        frame_start_d = v_wrap;
        animate_d     = h_wrap && (o_y == Y_W'(V_ACTIVE - 1));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            animate_q     <= 1'b0;
        end else begin
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            animate_q     <= animate_d;
        end
    end

    assign o_line_start  = line_start_q;
    assign o_frame_start = frame_start_q;
    assign o_animate     = animate_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   seen_frame_q, seen_frame_d;

    // The first frame start after reset opens frame 0 rather than closing one
    always_comb begin
        frame_cnt_d  = frame_cnt_q;
        seen_frame_d = seen_frame_q;
        if (frame_start_d) begin
            seen_frame_d = 1'b1;
            if (seen_frame_q) begin
                frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frame_cnt_q  <= '0;
            seen_frame_q <= 1'b0;
        end else begin
            frame_cnt_q  <= frame_cnt_d;
            seen_frame_q <= seen_frame_d;
        end
    end

    assign o_frame_cnt = frame_cnt_q;
`endif

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised raster timing generator for any VGA-class mode. It runs from one system clock with a pixel-rate enable strobe. It emits horizontal and vertical sync pulses with configurable polarity, active-video and blanking levels, raw beam coordinates, and one-cycle line, frame and end-of-active strobes. It sits between the clock/reset block and the pixel pipeline (framebuffer reader, sprite/animation logic), which consume its coordinates and strobes.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, asserted level of o_hs (0 = active-low)
- V_POL, 0, asserted level of o_vs
- FRAME_CNT_W, 16, width of o_frame_cnt
- i_clk  in  1  system clock; one clock, all logic on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_pix_en  in  1  pixel strobe; the beam advances one pixel per cycle with i_pix_en=1
- i_restart  in  1  synchronous frame restart
- o_hs / o_vs  out  1  sync outputs, polarity per H_POL/V_POL
- o_active  out  1  beam in visible region
- o_blanking  out  1  always ~o_active
- o_x  out  X_W=$clog2(H_TOTAL)  raw horizontal count 0..H_TOTAL-1
- o_y  out  Y_W=$clog2(V_TOTAL)  raw vertical count 0..V_TOTAL-1
- o_line_start  out  1  one-cycle pulse when the beam enters x=0
- o_frame_start  out  1  one-cycle pulse when the beam enters (0,0)
- o_animate  out  1  one-cycle pulse when the beam enters (0,V_ACTIVE), the first blank line
- o_frame_cnt  out  FRAME_CNT_W  completed-frame counter (macro-gated)

## Operation
- Derived totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP
- Every parameter must be ≥1; elaboration fails otherwise.
- Line order is active, front porch, sync, back porch. Frame order is the same, counted in lines.
- On a cycle with i_pix_en=1:
  - h increments.
  - At H_TOTAL-1, h wraps to 0 and v increments.
  - At V_TOTAL-1 with h wrapping, v wraps to 0.
- o_hs is asserted when h ∈ [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- o_vs is asserted when v ∈ [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC). o_vs changes only on h-wrap edges.
- o_active = (h<H_ACTIVE)&&(v<V_ACTIVE).
- o_x and o_y are the raw counters. They are meaningful to consumers only while o_active=1.
- Reset and restart state is the last pixel of the frame: h=H_TOTAL-1, v=V_TOTAL-1. The first advancing pixel is therefore always (0,0) with o_frame_start.
- i_restart=1 has priority over i_pix_en. While it is high:
  - counters are held at the reset position;
  - level outputs take their reset values;
  - strobes are held 0.
- i_pix_en=0 freezes all counters and level outputs.

## Timing
- All outputs are registered and decoded from next-state counters. Levels and coordinates therefore change on the same edge as the counters, with zero latency relative to o_x/o_y.
- Strobes go high on the advancing edge and clear on the next i_clk edge, giving exactly one i_clk cycle regardless of the i_pix_en duty.
- Reset values:
  - o_x=H_TOTAL-1, o_y=V_TOTAL-1
  - o_hs=~H_POL, o_vs=~V_POL
  - o_active=0, o_blanking=1
  - all strobes 0
  - o_frame_cnt=0
- Asynchronous assertion of i_rst_n mid-line forces the reset values immediately.
- Deassertion is synchronised upstream. The first advancing edge afterwards produces (0,0), with o_line_start=o_frame_start=1.
- o_frame_start and o_line_start pulse on the same edge.
- o_animate and o_line_start coincide at the start of line V_ACTIVE.

## Configuration
- VGA_TIMING_FRAME_CNT_EN defined:
  - o_frame_cnt exists.
  - It increments (mod 2^FRAME_CNT_W) on every o_frame_start edge except the first after reset.
  - It is cleared only by i_rst_n; i_restart does not clear it.
- Undefined: the port and register are absent.

## Structure
- vga_timing_pkg holds:
  - mode constant sets (640x480@60, 800x600@60: active/fp/sync/bp/polarity);
  - a function returning total from the four segments.
- Sub-module vga_axis_counter is instantiated twice, once for h and once for v.
  - Parameters: ACTIVE, FP, SYNC, BP, POL.
  - Inputs: clock, reset, i_adv, i_restart.
  - Outputs: count, next-wrap, sync, active.
  - The h instance's wrap drives the v instance's i_adv.

## Test plan
Small mode throughout: H 4/1/2/1 (total 8), V 3/1/1/1 (total 6), polarities 0.
- Reset release with i_pix_en=1 every cycle -> first edge x=0,y=0, o_active=1, o_frame_start=o_line_start=1 for one cycle; frame period exactly 48 cycles.
- Continuous run -> o_hs=0 exactly at x=5,6; o_vs=0 for all of y=4; o_active only for x<4, y<3.
- i_pix_en at 1-in-4 duty -> each coordinate held 4 cycles; o_line_start still one cycle wide; frame period 192 cycles.
- i_restart pulsed at (x=2,y=1) with i_pix_en=1 -> next state x=7,y=5, strobes 0; following advance gives (0,0) with o_frame_start.
- i_rst_n asserted mid-frame at (3,2) -> outputs immediately at reset values without a clock edge.
- With VGA_TIMING_FRAME_CNT_EN, FRAME_CNT_W=2, 6 frames -> o_frame_cnt sequence 0,1,2,3,0,1; unchanged by i_restart.
